// File: rtl/core_pkg.sv
// ============================================================================
// Package : core_pkg
// Purpose : Shared types and constants for the rotate-engine tile scheduler
//           and its tile coordinate mapper.
// Contents: state_t   - scheduler FSM encoding
//           ROT_*     - effective clockwise rotation codes
//           DIR_*     - rotation direction codes
//           eff_rot() - folds (degrees, direction) into a clockwise code
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int TILE_LOG2_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WAIT_DMA = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_RUN      = 3'd4,
        ST_NEXT     = 3'd5,
        ST_FIN      = 3'd6,
        ST_ERR      = 3'd7
    } state_t;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // A counter-clockwise turn of N quarter-steps equals a clockwise turn of
    // (4-N) mod 4, which is simply the 2-bit two's-complement negation.
    function automatic logic [1:0] eff_rot(input logic [1:0] deg, input logic dir);
        return (dir == DIR_CCW) ? (2'd0 - deg) : deg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_tile_map.sv
// ============================================================================
// Module  : core_tile_map
// Purpose : Combinational source-tile to destination-tile coordinate mapping
//           for a clockwise rotation of 0/90/180/270 degrees.
// Ports   : tx, ty     in  CW  source tile column / row
//           tw, th     in  CW  source image width / height in tiles
//           rot        in  2   effective clockwise rotation code (ROT_*)
//           dst_tx/ty  out CW  destination tile column / row
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_tile_map
    import core_pkg::*;
#(
    parameter int CW = 13
) (
    input  logic [CW-1:0] tx,
    input  logic [CW-1:0] ty,
    input  logic [CW-1:0] tw,
    input  logic [CW-1:0] th,
    input  logic [1:0]    rot,
    output logic [CW-1:0] dst_tx,
    output logic [CW-1:0] dst_ty
);

    always_comb begin
        dst_tx = tx;
        dst_ty = ty;
        case (rot)
            ROT_90: begin
                dst_tx = th - CW'(1) - ty;
                dst_ty = tx;
            end
            ROT_180: begin
                dst_tx = tw - CW'(1) - tx;
                dst_ty = th - CW'(1) - ty;
            end
            ROT_270: begin
                dst_tx = ty;
                dst_ty = tw - CW'(1) - tx;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/core_tile_ctrl.sv
// ============================================================================
// Module  : core_tile_ctrl
// Purpose : Tile scheduler for the rotate engine. Validates the job, walks the
//           source image in row-major tiles, waits for DMA per tile, fires
//           core_pixel once per tile and waits for it, with a watchdog.
// Ports   : I_HCLK, I_HRESET_N      clock, async active-low reset
//           I_START                 job start pulse (honoured in IDLE only)
//           I_HEIGHT/I_WIDTH        source geometry, pixels
//           I_DEGREES/I_DIRECTION   rotation amount and direction
//           I_DMA_READY             DMA can service the next tile
//           I_PIX_DONE              core_pixel finished current tile
//           O_PIX_START             one-cycle start to core_pixel
//           O_SRC_TX/TY, O_DST_TX/TY  tile coordinates for current tile
//           O_OUT_WIDTH/HEIGHT      rotated image geometry
//           O_BUSY, O_DONE, O_ERR   job status
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_tile_ctrl
    import core_pkg::*;
#(
    parameter int TILE_LOG2 = TILE_LOG2_DEF,
    parameter int TIMEOUT_W = 12
) (
    input  logic                    I_HCLK,
    input  logic                    I_HRESET_N,
    input  logic                    I_START,
    input  logic [15:0]             I_HEIGHT,
    input  logic [15:0]             I_WIDTH,
    input  logic [1:0]              I_DEGREES,
    input  logic                    I_DIRECTION,
    input  logic                    I_DMA_READY,
    input  logic                    I_PIX_DONE,
    output logic                    O_PIX_START,
    output logic [16-TILE_LOG2-1:0] O_SRC_TX,
    output logic [16-TILE_LOG2-1:0] O_SRC_TY,
    output logic [16-TILE_LOG2-1:0] O_DST_TX,
    output logic [16-TILE_LOG2-1:0] O_DST_TY,
    output logic [15:0]             O_OUT_WIDTH,
    output logic [15:0]             O_OUT_HEIGHT,
    output logic                    O_BUSY,
    output logic                    O_DONE,
    output logic                    O_ERR
);

    localparam int CW = 16 - TILE_LOG2;

    state_t             state, state_nx;
    logic [15:0]        cfg_h, cfg_w;
    logic [1:0]         cfg_deg;
    logic               cfg_dir;
    logic [CW-1:0]      tx, ty, dtx, dty;
    logic [CW-1:0]      nx, ny, map_tx, map_ty;
    logic [15:0]        out_w, out_h;
    logic [TIMEOUT_W-1:0] wd;
    logic               err_q;

    logic [CW-1:0]      tw, th;
    logic [1:0]         rot;
    logic               cfg_bad, last_tx, last_ty, wd_exp;

    assign tw      = cfg_w[15:TILE_LOG2];
    assign th      = cfg_h[15:TILE_LOG2];
    assign rot     = eff_rot(cfg_deg, cfg_dir);
    assign cfg_bad = (cfg_h == 16'd0) || (cfg_w == 16'd0) ||
                     (|cfg_h[TILE_LOG2-1:0]) || (|cfg_w[TILE_LOG2-1:0]);
    assign last_tx = (tx == tw - CW'(1));
    assign last_ty = (ty == th - CW'(1));
    assign wd_exp  = &wd;

    // Coordinates of the tile that becomes current at the next edge: origin
    // when a job is being validated, otherwise the row-major successor.
    always_comb begin
        nx = tx;
        ny = ty;
        if (state == ST_CHECK) begin
            nx = '0;
            ny = '0;
        end else if (last_tx) begin
            nx = '0;
            ny = ty + CW'(1);
        end else begin
            nx = tx + CW'(1);
        end
    end

    core_tile_map #(
        .CW (CW)
    ) u_map (
        .tx     (nx),
        .ty     (ny),
        .tw     (tw),
        .th     (th),
        .rot    (rot),
        .dst_tx (map_tx),
        .dst_ty (map_ty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (I_START) state_nx = ST_CHECK;
            ST_CHECK:    state_nx = cfg_bad ? ST_ERR : ST_WAIT_DMA;
            ST_WAIT_DMA: if (I_DMA_READY) state_nx = ST_ISSUE;
            ST_ISSUE:    state_nx = ST_RUN;
            // Completion takes priority over a watchdog expiring in the same cycle.
            ST_RUN: begin
                if (I_PIX_DONE)  state_nx = ST_NEXT;
                else if (wd_exp) state_nx = ST_ERR;
            end
            ST_NEXT:     state_nx = (last_tx && last_ty) ? ST_FIN : ST_WAIT_DMA;
            ST_FIN:      state_nx = ST_IDLE;
            ST_ERR:      state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            cfg_h   <= '0;
            cfg_w   <= '0;
            cfg_deg <= '0;
            cfg_dir <= 1'b0;
            tx      <= '0;
            ty      <= '0;
            dtx     <= '0;
            dty     <= '0;
            out_w   <= '0;
            out_h   <= '0;
            wd      <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && I_START) begin
                cfg_h   <= I_HEIGHT;
                cfg_w   <= I_WIDTH;
                cfg_deg <= I_DEGREES;
                cfg_dir <= I_DIRECTION;
                err_q   <= 1'b0;
            end

            if (state == ST_CHECK) begin
                out_w <= rot[0] ? cfg_h : cfg_w;
                out_h <= rot[0] ? cfg_w : cfg_h;
                if (cfg_bad) err_q <= 1'b1;
            end

            // Coordinates move only when a new tile is selected, so they
            // stay stable through ISSUE/RUN and hold after the last tile.
            if ((state == ST_CHECK && !cfg_bad) ||
                (state == ST_NEXT && !(last_tx && last_ty))) begin
                tx  <= nx;
                ty  <= ny;
                dtx <= map_tx;
                dty <= map_ty;
            end

            if (state == ST_ISSUE) begin
                wd <= '0;
            end else if (state == ST_RUN && !wd_exp) begin
                wd <= wd + TIMEOUT_W'(1);
            end

            if (state == ST_RUN && !I_PIX_DONE && wd_exp) err_q <= 1'b1;
        end
    end

    assign O_PIX_START  = (state == ST_ISSUE);
    assign O_DONE       = (state == ST_FIN);
    assign O_BUSY       = (state != ST_IDLE);
    assign O_ERR        = err_q;
    assign O_SRC_TX     = tx;
    assign O_SRC_TY     = ty;
    assign O_DST_TX     = dtx;
    assign O_DST_TY     = dty;
    assign O_OUT_WIDTH  = out_w;
    assign O_OUT_HEIGHT = out_h;

endmodule

`default_nettype wire

// File: tb/tb_core_tile_ctrl.sv
// ============================================================================
// Module  : tb_core_tile_ctrl
// Purpose : Self-checking bench for core_tile_ctrl: table of rotate jobs with
//           hand-computed geometry and destination tile sequences, plus
//           directed sequences for DMA stall, watchdog and reset abort.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_tile_ctrl;

    logic        I_HCLK = 1'b0;
    logic        I_HRESET_N;
    logic        I_START;
    logic [15:0] I_HEIGHT, I_WIDTH;
    logic [1:0]  I_DEGREES;
    logic        I_DIRECTION, I_DMA_READY, I_PIX_DONE;
    logic        O_PIX_START, O_BUSY, O_DONE, O_ERR;
    logic [12:0] O_SRC_TX, O_SRC_TY, O_DST_TX, O_DST_TY;
    logic [15:0] O_OUT_WIDTH, O_OUT_HEIGHT;

    int tests = 0;
    int fails = 0;

    core_tile_ctrl dut (
        .I_HCLK       (I_HCLK),
        .I_HRESET_N   (I_HRESET_N),
        .I_START      (I_START),
        .I_HEIGHT     (I_HEIGHT),
        .I_WIDTH      (I_WIDTH),
        .I_DEGREES    (I_DEGREES),
        .I_DIRECTION  (I_DIRECTION),
        .I_DMA_READY  (I_DMA_READY),
        .I_PIX_DONE   (I_PIX_DONE),
        .O_PIX_START  (O_PIX_START),
        .O_SRC_TX     (O_SRC_TX),
        .O_SRC_TY     (O_SRC_TY),
        .O_DST_TX     (O_DST_TX),
        .O_DST_TY     (O_DST_TY),
        .O_OUT_WIDTH  (O_OUT_WIDTH),
        .O_OUT_HEIGHT (O_OUT_HEIGHT),
        .O_BUSY       (O_BUSY),
        .O_DONE       (O_DONE),
        .O_ERR        (O_ERR)
    );

    always #5 I_HCLK = ~I_HCLK;

    // dseq: nibble i = {dst_tx[1:0], dst_ty[1:0]} of the i-th source tile.
    typedef struct packed {
        logic [15:0] h;
        logic [15:0] w;
        logic [1:0]  deg;
        logic        dir;
        logic        bad;
        logic [15:0] ow;
        logic [15:0] oh;
        logic [2:0]  n;
        logic [15:0] dseq;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [15:0] h, w, input logic [1:0] deg,
                                input logic dir, bad, input logic [15:0] ow, oh,
                                input logic [2:0] n, input logic [15:0] dseq);
        vec_t v;
        v.h = h; v.w = w; v.deg = deg; v.dir = dir; v.bad = bad;
        v.ow = ow; v.oh = oh; v.n = n; v.dseq = dseq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge I_HCLK);
        #1;
    endtask

    task automatic run_job(input vec_t v);
        int          lat;
        logic        seen;
        logic [12:0] tw;
        tw = v.w[15:3];
        I_HEIGHT = v.h; I_WIDTH = v.w; I_DEGREES = v.deg; I_DIRECTION = v.dir;
        I_START = 1'b1;
        step();
        I_START = 1'b0;
        // Scramble config: the job must run on the values latched at START.
        I_WIDTH = 16'd12; I_HEIGHT = 16'd0; I_DEGREES = ~v.deg; I_DIRECTION = ~v.dir;
        chk("busy_after_start", O_BUSY, 1);
        chk("err_cleared_by_start", O_ERR, 0);
        if (v.bad) begin
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                step();
                if (O_PIX_START || O_DONE) seen = 1'b1;
            end
            chk("bad_job_no_start", seen, 0);
            chk("bad_job_err", O_ERR, 1);
            chk("bad_job_busy_drop", O_BUSY, 0);
            return;
        end
        for (int i = 0; i < int'(v.n); i++) begin
            lat = (i == 0) ? 1 : 0;
            while (!O_PIX_START && lat < 40) begin
                step();
                lat++;
            end
            if (i == 0) chk("first_start_latency", lat, 3);
            else        chk("tile_start_seen", O_PIX_START, 1);
            chk("src_tx", O_SRC_TX, 13'(i % int'(tw)));
            chk("src_ty", O_SRC_TY, 13'(i / int'(tw)));
            chk("dst_tx", O_DST_TX, 13'(v.dseq[4*i+2 +: 2]));
            chk("dst_ty", O_DST_TY, 13'(v.dseq[4*i +: 2]));
            step();
            chk("pix_start_one_cycle", O_PIX_START, 0);
            step();
            I_PIX_DONE = 1'b1;
            step();
            I_PIX_DONE = 1'b0;
        end
        step();
        chk("done_2_after_pix_done", O_DONE, 1);
        chk("out_width", O_OUT_WIDTH, v.ow);
        chk("out_height", O_OUT_HEIGHT, v.oh);
        step();
        chk("done_one_cycle", O_DONE, 0);
        chk("busy_idle_after_done", O_BUSY, 0);
    endtask

    initial begin : main
        int   cnt;
        logic seen;

        //           H       W     DEG  DIR  BAD  OW     OH     N     DSEQ
        vecs[0]  = mk(16'd8,  16'd8,  2'd1, 1'b0, 1'b0, 16'd8,  16'd8,  3'd1, 16'h0000);
        vecs[1]  = mk(16'd8,  16'd16, 2'd1, 1'b0, 1'b0, 16'd8,  16'd16, 3'd2, 16'h0010);
        vecs[2]  = mk(16'd16, 16'd16, 2'd2, 1'b0, 1'b0, 16'd16, 16'd16, 3'd4, 16'h0415);
        vecs[3]  = mk(16'd8,  16'd12, 2'd0, 1'b0, 1'b1, 16'd0,  16'd0,  3'd0, 16'h0000);
        vecs[4]  = mk(16'd16, 16'd16, 2'd1, 1'b1, 1'b0, 16'd16, 16'd16, 3'd4, 16'h4501);
        vecs[5]  = mk(16'd16, 16'd16, 2'd3, 1'b0, 1'b0, 16'd16, 16'd16, 3'd4, 16'h4501);
        vecs[6]  = mk(16'd0,  16'd8,  2'd0, 1'b0, 1'b1, 16'd0,  16'd0,  3'd0, 16'h0000);
        vecs[7]  = mk(16'd16, 16'd16, 2'd0, 1'b0, 1'b0, 16'd16, 16'd16, 3'd4, 16'h5140);
        vecs[8]  = mk(16'd16, 16'd16, 2'd1, 1'b0, 1'b0, 16'd16, 16'd16, 3'd4, 16'h1054);
        vecs[9]  = mk(16'd16, 16'd8,  2'd2, 1'b1, 1'b0, 16'd8,  16'd16, 3'd2, 16'h0001);
        vecs[10] = mk(16'd24, 16'd8,  2'd3, 1'b1, 1'b0, 16'd24, 16'd8,  3'd3, 16'h0048);

        I_HRESET_N = 1'b0; I_START = 1'b0; I_HEIGHT = '0; I_WIDTH = '0;
        I_DEGREES = '0; I_DIRECTION = 1'b0; I_DMA_READY = 1'b1; I_PIX_DONE = 1'b0;
        #12;
        chk("rst_busy", O_BUSY, 0);
        chk("rst_done", O_DONE, 0);
        chk("rst_err", O_ERR, 0);
        chk("rst_pix_start", O_PIX_START, 0);
        chk("rst_out_w", O_OUT_WIDTH, 0);
        chk("rst_dst_tx", O_DST_TX, 0);
        step();
        I_HRESET_N = 1'b1;
        step();

        for (int i = 0; i < 11; i++) run_job(vecs[i]);

        // DMA stall: nothing issues while READY is low; stray PIX_DONE ignored.
        I_DMA_READY = 1'b0;
        I_HEIGHT = 16'd8; I_WIDTH = 16'd8; I_DEGREES = 2'd0; I_DIRECTION = 1'b0;
        I_START = 1'b1;
        step();
        I_START = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 22; k++) begin
            I_PIX_DONE = (k % 5 == 0);
            step();
            if (O_PIX_START || O_DONE) seen = 1'b1;
        end
        I_PIX_DONE = 1'b0;
        chk("dma_low_no_start", seen, 0);
        chk("dma_low_busy", O_BUSY, 1);
        I_DMA_READY = 1'b1;
        step();
        chk("dma_ready_start_next", O_PIX_START, 1);
        step();
        I_PIX_DONE = 1'b1;
        step();
        I_PIX_DONE = 1'b0;
        step();
        chk("dma_job_done", O_DONE, 1);
        step();

        // Watchdog: PIX_DONE withheld after the start pulse.
        I_START = 1'b1;
        step();
        I_START = 1'b0;
        cnt = 0;
        while (!O_PIX_START && cnt < 20) begin
            step();
            cnt++;
        end
        chk("wd_start_seen", O_PIX_START, 1);
        cnt = 0;
        while (!O_ERR && cnt < 5000) begin
            step();
            cnt++;
        end
        chk("wd_timeout_cycles", cnt, 4097);
        // START during the ERR cycle must not be accepted.
        I_START = 1'b1;
        step();
        I_START = 1'b0;
        chk("wd_busy_drop", O_BUSY, 0);
        chk("wd_err_sticky", O_ERR, 1);
        I_PIX_DONE = 1'b1;
        step();
        I_PIX_DONE = 1'b0;
        chk("start_in_err_ignored", O_BUSY, 0);

        // Reset mid-RUN aborts immediately.
        I_HEIGHT = 16'd16; I_WIDTH = 16'd16; I_DEGREES = 2'd2; I_DIRECTION = 1'b0;
        I_START = 1'b1;
        step();
        I_START = 1'b0;
        cnt = 0;
        while (!O_PIX_START && cnt < 20) begin
            step();
            cnt++;
        end
        chk("rr_dst_before", O_DST_TX, 1);
        step();
        #2 I_HRESET_N = 1'b0;
        #1;
        chk("rr_busy", O_BUSY, 0);
        chk("rr_dst_tx", O_DST_TX, 0);
        chk("rr_out_w", O_OUT_WIDTH, 0);
        chk("rr_err", O_ERR, 0);
        step();
        I_HRESET_N = 1'b1;
        I_PIX_DONE = 1'b1;
        step();
        I_PIX_DONE = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (O_PIX_START || O_DONE || O_BUSY) seen = 1'b1;
        end
        chk("rr_no_activity", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
